// File: rtl/esn_pkg.sv
// Shared encodings for the ESN heap sequencer: FSM states, heap mode codes
// and block-select codes.
package esn_pkg;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_READ   = 3'd2;
   localparam logic [2:0] S_DRAIN  = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_OUT    = 3'd5;
   localparam logic [2:0] S_ODRAIN = 3'd6;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_LOAD = 2'b01;
   localparam logic [1:0] ST_RUN  = 2'b10;

   localparam logic [2:0] SEL_X    = 3'd0;
   localparam logic [2:0] SEL_W    = 3'd1;
   localparam logic [2:0] SEL_WIN  = 3'd2;
   localparam logic [2:0] SEL_WINB = 3'd3;
   localparam logic [2:0] SEL_WOUT = 3'd4;
   localparam logic [2:0] SEL_NONE = 3'd7;

   function automatic logic [1:0] sram_code(input logic [2:0] s);
      case (s)
         S_IDLE:  return ST_IDLE;
         S_LOAD:  return ST_LOAD;
         default: return ST_RUN;
      endcase
   endfunction

endpackage

// File: rtl/esn_rd_valid_pipe.sv
// Delays the heap read-enable activity and sweep-end markers by RD_LAT cycles
// so they line up with the data emerging from the heap.
module esn_rd_valid_pipe #(
   parameter int RD_LAT = 3
) (
   input  logic clk,
   input  logic nrst,
   input  logic in_valid,
   input  logic in_last,
   output logic out_valid,
   output logic out_last
);

   logic [RD_LAT-1:0] v_sr;
   logic [RD_LAT-1:0] l_sr;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         v_sr <= '0;
         l_sr <= '0;
      end else begin
         v_sr[0] <= in_valid;
         l_sr[0] <= in_last;
         for (int i = 1; i < RD_LAT; i++) begin
            v_sr[i] <= v_sr[i-1];
            l_sr[i] <= l_sr[i-1];
         end
      end
   end

   assign out_valid = v_sr[RD_LAT-1];
   assign out_last  = l_sr[RD_LAT-1];

endmodule

// File: rtl/esn_heap_sequencer.sv
// Top-level ESN heap sequencer: off-chip load, reservoir update sweeps with PE
// write-back, and a final readout sweep.
module esn_heap_sequencer
   import esn_pkg::*;
#(
   parameter int addr_length = 10,
   parameter int bit_length  = 32,
   parameter int node_num    = 1000,
   parameter int RD_LAT      = 3,
   parameter int STEP_W      = 16
) (
   input  logic                   clk,
   input  logic                   nrst,
   input  logic                   start_load,
   input  logic                   start_run,
   input  logic [STEP_W-1:0]      num_steps,
   input  logic                   load_valid,
   input  logic [bit_length-1:0]  load_data,
   output logic                   load_ready,
   output logic [1:0]             SRAM_State,
   output logic [2:0]             SEL_inSRAM_offchip,
   output logic [addr_length-1:0] addr_inSRAM_offchip,
   output logic [bit_length-1:0]  Data_offchip,
   output logic                   EN_X_inSRAM_n,
   output logic                   EN_update_addr_X_n,
   output logic                   EN_update_addr_W_n,
   output logic                   EN_update_addr_Win_n,
   output logic                   EN_update_addr_Winb_n,
   output logic                   EN_update_addr_Wout_n,
   output logic                   pe_rd_valid,
   output logic                   pe_rd_last,
   output logic                   pe_rd_mode,
   input  logic                   pe_wb_valid,
   output logic                   pe_wb_ready,
   output logic                   busy,
   output logic                   done,
   output logic [STEP_W-1:0]      step_cnt
);

   localparam logic [addr_length-1:0] CNT_LAST   = addr_length'(node_num - 1);
   localparam logic [addr_length-1:0] DRAIN_LAST = addr_length'(RD_LAT - 1);

   logic [2:0]             state, state_next;
   logic [addr_length-1:0] cnt;
   logic [addr_length-1:0] widx;
   logic [2:0]             blk;
   logic [STEP_W-1:0]      steps_q;
   logic [STEP_W-1:0]      step_inc;
   logic                   beat, wb_acc, sweep_end, drain_end, load_end, rd_fin;

   always_comb begin
      beat       = (state == S_LOAD) && load_valid;
      wb_acc     = (state == S_WB) && pe_wb_valid;
      sweep_end  = (cnt == CNT_LAST);
      drain_end  = (cnt == DRAIN_LAST);
      load_end   = beat && (widx == CNT_LAST) && (blk == SEL_WOUT);
      step_inc   = step_cnt + 1'b1;
      state_next = state;
      case (state)
         S_IDLE: begin
            if (start_load)     state_next = S_LOAD;
            else if (start_run) state_next = (num_steps == '0) ? S_OUT : S_READ;
         end
         S_LOAD:   if (load_end)  state_next = S_IDLE;
         S_READ:   if (sweep_end) state_next = S_DRAIN;
         S_DRAIN:  if (drain_end) state_next = S_WB;
         S_WB:     if (wb_acc && sweep_end) state_next = (step_inc < steps_q) ? S_READ : S_OUT;
         S_OUT:    if (sweep_end) state_next = S_ODRAIN;
         S_ODRAIN: if (drain_end) state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   // Heap-facing outputs follow the state one cycle late, so the write-back enable
   // of the last PE word never overlaps the first read enable of the next sweep.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state                 <= S_IDLE;
         cnt                   <= '0;
         widx                  <= '0;
         blk                   <= '0;
         steps_q               <= '0;
         step_cnt              <= '0;
         SRAM_State            <= ST_IDLE;
         SEL_inSRAM_offchip    <= SEL_NONE;
         addr_inSRAM_offchip   <= '0;
         Data_offchip          <= '0;
         EN_X_inSRAM_n         <= 1'b1;
         EN_update_addr_X_n    <= 1'b1;
         EN_update_addr_W_n    <= 1'b1;
         EN_update_addr_Win_n  <= 1'b1;
         EN_update_addr_Winb_n <= 1'b1;
         EN_update_addr_Wout_n <= 1'b1;
         rd_fin                <= 1'b0;
         pe_rd_mode            <= 1'b0;
         load_ready            <= 1'b0;
         pe_wb_ready           <= 1'b0;
         busy                  <= 1'b0;
         done                  <= 1'b0;
      end else begin
         state       <= state_next;
         SRAM_State  <= sram_code(state);
         busy        <= (state_next != S_IDLE);
         load_ready  <= (state_next == S_LOAD);
         pe_wb_ready <= (state_next == S_WB);
         done        <= (state == S_ODRAIN) && (state_next == S_IDLE);

         SEL_inSRAM_offchip <= beat ? blk : SEL_NONE;
         if (beat) begin
            addr_inSRAM_offchip <= widx;
            Data_offchip        <= load_data;
         end

         EN_update_addr_X_n    <= !((state == S_READ) || (state == S_OUT));
         EN_update_addr_W_n    <= (state != S_READ);
         EN_update_addr_Win_n  <= (state != S_READ);
         EN_update_addr_Winb_n <= (state != S_READ);
         EN_update_addr_Wout_n <= (state != S_OUT);
         EN_X_inSRAM_n         <= !wb_acc;
         rd_fin                <= ((state == S_READ) || (state == S_OUT)) && sweep_end;

         // Mode is sticky so it still covers the readout words draining after OUT.
         if (state == S_OUT)       pe_rd_mode <= 1'b1;
         else if (state == S_READ) pe_rd_mode <= 1'b0;

         if (state_next != state)
            cnt <= '0;
         else if ((state == S_READ) || (state == S_OUT) || (state == S_DRAIN) ||
                  (state == S_ODRAIN) || wb_acc)
            cnt <= cnt + 1'b1;

         if ((state == S_IDLE) && (state_next == S_LOAD)) begin
            widx <= '0;
            blk  <= '0;
         end else if (beat) begin
            if (widx == CNT_LAST) begin
               widx <= '0;
               blk  <= (blk == SEL_WOUT) ? SEL_X : blk + 1'b1;
            end else begin
               widx <= widx + 1'b1;
            end
         end

         if ((state == S_IDLE) && start_run && !start_load) begin
            steps_q  <= num_steps;
            step_cnt <= '0;
         end else if (wb_acc && sweep_end) begin
            step_cnt <= step_inc;
         end
      end
   end

   esn_rd_valid_pipe #(
      .RD_LAT (RD_LAT)
   ) u_rd_pipe (
      .clk       (clk),
      .nrst      (nrst),
      .in_valid  (~EN_update_addr_X_n),
      .in_last   (rd_fin),
      .out_valid (pe_rd_valid),
      .out_last  (pe_rd_last)
   );

endmodule

// File: tb/tb_esn_heap_sequencer.sv
// Directed bench for esn_heap_sequencer with a load-write scoreboard and
// per-cycle checks of the read-valid pipeline and write-back enables.
module tb_esn_heap_sequencer;
   import esn_pkg::*;

   localparam int AW = 4;
   localparam int BW = 16;
   localparam int NN = 4;
   localparam int RL = 3;
   localparam int SW = 8;

   logic          clk = 1'b0;
   logic          nrst = 1'b0;
   logic          start_load = 1'b0;
   logic          start_run = 1'b0;
   logic [SW-1:0] num_steps = '0;
   logic          load_valid = 1'b0;
   logic [BW-1:0] load_data = '0;
   logic          pe_wb_valid = 1'b0;
   logic          load_ready, pe_rd_valid, pe_rd_last, pe_rd_mode, pe_wb_ready, busy, done;
   logic [1:0]    SRAM_State;
   logic [2:0]    SEL_inSRAM_offchip;
   logic [AW-1:0] addr_inSRAM_offchip;
   logic [BW-1:0] Data_offchip;
   logic          EN_X_inSRAM_n, EN_update_addr_X_n, EN_update_addr_W_n;
   logic          EN_update_addr_Win_n, EN_update_addr_Winb_n, EN_update_addr_Wout_n;
   logic [SW-1:0] step_cnt;

   always #5 clk = ~clk;

   esn_heap_sequencer #(
      .addr_length (AW),
      .bit_length  (BW),
      .node_num    (NN),
      .RD_LAT      (RL),
      .STEP_W      (SW)
   ) dut (
      .clk                   (clk),
      .nrst                  (nrst),
      .start_load            (start_load),
      .start_run             (start_run),
      .num_steps             (num_steps),
      .load_valid            (load_valid),
      .load_data             (load_data),
      .load_ready            (load_ready),
      .SRAM_State            (SRAM_State),
      .SEL_inSRAM_offchip    (SEL_inSRAM_offchip),
      .addr_inSRAM_offchip   (addr_inSRAM_offchip),
      .Data_offchip          (Data_offchip),
      .EN_X_inSRAM_n         (EN_X_inSRAM_n),
      .EN_update_addr_X_n    (EN_update_addr_X_n),
      .EN_update_addr_W_n    (EN_update_addr_W_n),
      .EN_update_addr_Win_n  (EN_update_addr_Win_n),
      .EN_update_addr_Winb_n (EN_update_addr_Winb_n),
      .EN_update_addr_Wout_n (EN_update_addr_Wout_n),
      .pe_rd_valid           (pe_rd_valid),
      .pe_rd_last            (pe_rd_last),
      .pe_rd_mode            (pe_rd_mode),
      .pe_wb_valid           (pe_wb_valid),
      .pe_wb_ready           (pe_wb_ready),
      .busy                  (busy),
      .done                  (done),
      .step_cnt              (step_cnt)
   );

   typedef struct packed {
      logic [2:0]    sel;
      logic [AW-1:0] addr;
      logic [BW-1:0] data;
   } wr_t;

   wr_t           wr_q[$];
   int            tot = 0;
   int            bad = 0;
   int            wr_seen = 0;
   int            vidx = 0;
   logic [RL-1:0] hist = '0;
   logic          exp_mode = 1'b0;
   logic          acc_prev = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tot++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: remember this cycle's write-back handshake, move to the next
   // negedge and check everything the DUT produced for the new cycle.
   task automatic tick();
      wr_t e;
      acc_prev = pe_wb_ready & pe_wb_valid;
      @(negedge clk);
      if (!nrst) begin
         hist = '0;
         vidx = 0;
      end else begin
         if (SEL_inSRAM_offchip !== SEL_NONE) begin
            wr_seen++;
            if (wr_q.size() == 0) begin
               check("unexpected_wr", SEL_inSRAM_offchip, SEL_NONE);
            end else begin
               e = wr_q.pop_front();
               check("wr_sel", SEL_inSRAM_offchip, e.sel);
               check("wr_addr", addr_inSRAM_offchip, e.addr);
               check("wr_data", Data_offchip, e.data);
               check("wr_mode", SRAM_State, ST_LOAD);
            end
         end
         if (EN_X_inSRAM_n === 1'b0)
            check("en_overlap", {EN_update_addr_X_n, EN_update_addr_W_n, EN_update_addr_Win_n,
                                 EN_update_addr_Winb_n, EN_update_addr_Wout_n}, 5'h1f);
         check("wb_en", EN_X_inSRAM_n, !acc_prev);
         check("rd_valid", pe_rd_valid, hist[RL-1]);
         if (pe_rd_valid === 1'b1) begin
            check("rd_last", pe_rd_last, vidx == NN - 1);
            check("rd_mode", pe_rd_mode, exp_mode);
            vidx = (vidx == NN - 1) ? 0 : vidx + 1;
         end
         hist = {hist[RL-2:0], ~EN_update_addr_X_n};
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_mode_sel"}, {SRAM_State, SEL_inSRAM_offchip}, {ST_IDLE, SEL_NONE});
      check({tag, "_addr"}, addr_inSRAM_offchip, 0);
      check({tag, "_data"}, Data_offchip, 0);
      check({tag, "_en"}, {EN_X_inSRAM_n, EN_update_addr_X_n, EN_update_addr_W_n,
                           EN_update_addr_Win_n, EN_update_addr_Winb_n, EN_update_addr_Wout_n}, 6'h3f);
      check({tag, "_flags"}, {load_ready, pe_wb_ready, pe_rd_valid, pe_rd_last, pe_rd_mode, busy, done}, 7'h0);
      check({tag, "_step"}, step_cnt, 0);
   endtask

   // Waits out a reservoir read sweep, then feeds the write-back pattern.
   task automatic do_update(input int step_exp, input logic [15:0] pat, input int len, input bit last_step);
      int en_low = 0;
      int vcnt = 0;
      int n = 0;
      while (pe_wb_ready !== 1'b1 && n < 40) begin
         tick();
         n++;
         if (EN_update_addr_W_n === 1'b0) en_low++;
         if (pe_rd_valid === 1'b1) vcnt++;
      end
      check("wb_reached", n < 40, 1);
      check("rd_sweep_len", en_low, NN);
      check("rd_valid_cnt", vcnt, NN);
      check("run_mode", SRAM_State, ST_RUN);
      for (int i = 0; i < len; i++) begin
         check("wb_ready_hold", pe_wb_ready, 1);
         pe_wb_valid = pat[i];
         if (last_step && i == len - 1) exp_mode = 1'b1;
         tick();
      end
      pe_wb_valid = 1'b0;
      check("step_cnt", step_cnt, step_exp);
      check("wb_ready_drop", pe_wb_ready, 0);
   endtask

   task automatic do_out(input int exp_steps);
      int en_low = 0;
      int w_low = 0;
      int vcnt = 0;
      int wbr = 0;
      int n = 0;
      while (done !== 1'b1 && n < 60) begin
         tick();
         n++;
         if (EN_update_addr_Wout_n === 1'b0) en_low++;
         if (EN_update_addr_W_n === 1'b0) w_low++;
         if (pe_rd_valid === 1'b1) vcnt++;
         if (pe_wb_ready === 1'b1) wbr++;
      end
      check("done_seen", n < 60, 1);
      check("out_sweep_len", en_low, NN);
      check("out_w_quiet", w_low, 0);
      check("out_valid_cnt", vcnt, NN);
      check("out_no_wb", wbr, 0);
      check("busy_at_done", busy, 0);
      check("final_steps", step_cnt, exp_steps);
      tick();
      check("done_pulse", done, 0);
      check("idle_mode", SRAM_State, ST_IDLE);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired total=%0d bad=%0d", tot, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      wr_t e;
      repeat (2) tick();
      check_reset("por");
      nrst = 1'b1;
      tick();
      check("por_idle", busy, 0);

      // reset in the middle of a load
      start_load = 1'b1;
      tick();
      start_load = 1'b0;
      check("load_ready_on", load_ready, 1);
      for (int i = 0; i < 3; i++) begin
         load_valid = 1'b1;
         load_data = BW'(16'h5A00 + i);
         e.sel = SEL_X;
         e.addr = AW'(i);
         e.data = load_data;
         wr_q.push_back(e);
         tick();
         load_valid = 1'b0;
         tick();
      end
      #2 nrst = 1'b0;
      #1 check_reset("mid_load");
      tick();
      nrst = 1'b1;
      wr_q.delete();
      tick();
      check("idle_after_reset", {busy, load_ready}, 2'b00);

      // full load with gaps; simultaneous start picks load
      wr_seen = 0;
      start_load = 1'b1;
      start_run = 1'b1;
      num_steps = 8'd5;
      tick();
      start_load = 1'b0;
      start_run = 1'b0;
      check("load_wins", {load_ready, busy}, 2'b11);
      for (int i = 0; i < 5 * NN; i++) begin
         check("load_ready", load_ready, 1);
         load_valid = 1'b1;
         load_data = BW'(i * 37 + 5);
         e.sel = 3'(i / NN);
         e.addr = AW'(i % NN);
         e.data = load_data;
         wr_q.push_back(e);
         if (i == 7) start_run = 1'b1;
         tick();
         load_valid = 1'b0;
         start_run = 1'b0;
         if (i != 5 * NN - 1) begin
            tick();
            check("gap_sel", SEL_inSRAM_offchip, SEL_NONE);
            check("gap_en", {EN_X_inSRAM_n, EN_update_addr_X_n, EN_update_addr_W_n,
                             EN_update_addr_Win_n, EN_update_addr_Winb_n, EN_update_addr_Wout_n}, 6'h3f);
         end
      end
      check("load_exit", {busy, load_ready}, 2'b00);
      check("load_writes", wr_seen, 5 * NN);
      check("load_sb_empty", wr_q.size(), 0);
      check("run_ignored", step_cnt, 0);
      tick();
      check("load_idle_mode", SRAM_State, ST_IDLE);

      // two reservoir updates then readout
      exp_mode = 1'b0;
      num_steps = 8'd2;
      start_run = 1'b1;
      tick();
      start_run = 1'b0;
      check("run_busy", busy, 1);
      do_update(1, 16'b1111, 4, 1'b0);
      do_update(2, 16'b1011001, 7, 1'b1);
      do_out(2);

      // zero steps: readout only
      exp_mode = 1'b1;
      num_steps = 8'd0;
      start_run = 1'b1;
      tick();
      start_run = 1'b0;
      check("zero_busy", busy, 1);
      do_out(0);

      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
   end

endmodule

// File: doc/esn_heap_sequencer.md
Name: esn_heap_sequencer

Overview:
Top-level sequencer for the ESN SRAM heap. It streams off-chip weights and initial state into the heap (load mode), then runs num_steps reservoir updates. Each update is a read sweep of X/W/Win/Winb, a PE drain, and an X write-back from the PE. It finishes with one readout sweep of X/Wout. It drives every control input of the heap and gives the PE read-valid and write-back handshakes.

Parameters:
addr_length, 10, heap address width
bit_length, 32, data word width
node_num, 1000, words per heap block (one sweep length); 2 <= node_num <= 2^addr_length
RD_LAT, 3, cycles from an enable asserted low at this block's output to the heap data valid
STEP_W, 16, width of num_steps / step counter

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
start_load  in  1  pulse: begin load sequence (honoured only in IDLE)
start_run  in  1  pulse: begin run sequence (honoured only in IDLE)
num_steps  in  STEP_W  reservoir updates per run, sampled on start_run
load_valid  in  1  off-chip word valid
load_data  in  bit_length  off-chip word
load_ready  out  1  high in LOAD
SRAM_State  out  2  heap mode: 00 idle, 01 load, 10 run
SEL_inSRAM_offchip  out  3  target block in load: 0 X, 1 W, 2 Win, 3 Winb, 4 Wout; 7 = no write
addr_inSRAM_offchip  out  addr_length  load write address
Data_offchip  out  bit_length  load write data
EN_X_inSRAM_n, EN_update_addr_X_n, EN_update_addr_W_n, EN_update_addr_Win_n, EN_update_addr_Winb_n, EN_update_addr_Wout_n  out  1 each  active-low heap enables
pe_rd_valid  out  1  heap read data valid this cycle
pe_rd_last  out  1  last word of a sweep, qualified by pe_rd_valid
pe_rd_mode  out  1  0 reservoir sweep, 1 readout sweep
pe_wb_valid  in  1  PE result word valid (data goes to the heap on its Data_onchip input)
pe_wb_ready  out  1  high in WB
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse when the run completes
step_cnt  out  STEP_W  completed updates in the current run

Behaviour:
- All outputs are registered.
- Reset values:
  - SRAM_State=00, SEL=7, addr=0, Data_offchip=0.
  - All EN_*_n=1.
  - load_ready, pe_wb_ready, pe_rd_*, busy, done = 0; step_cnt=0.
  - All internal counters = 0.
  - Reset mid-operation aborts immediately to these values.
- States: IDLE, LOAD, READ, DRAIN, WB, OUT, ODRAIN.
- IDLE:
  - SRAM_State=00.
  - start_load goes to LOAD; otherwise start_run goes to READ (or to OUT if num_steps==0).
  - If both starts are high together, load wins.
  - Starts are ignored outside IDLE.
- LOAD:
  - SRAM_State=01, load_ready=1.
  - On each accepted beat (load_valid=1), the next cycle drives SEL=blk, addr=widx, Data_offchip=load_data.
  - On a cycle with no beat, SEL=7 (no write) and widx holds.
  - widx counts 0..node_num-1, then wraps to 0 and blk increments.
  - After the beat blk=4, widx=node_num-1, go to IDLE. Exactly 5*node_num writes occur.
- READ:
  - SRAM_State=10.
  - EN_update_addr_X_n, _W_n, _Win_n, _Winb_n are driven 0 for exactly node_num consecutive cycles, then 1.
  - Then go to DRAIN.
- DRAIN / ODRAIN:
  - All enables are 1.
  - Wait RD_LAT cycles so the last read word emerges.
  - DRAIN goes to WB; ODRAIN goes to IDLE and pulses done.
- WB:
  - pe_wb_ready=1.
  - Each cycle with pe_wb_valid=1 drives EN_X_inSRAM_n=0 the next cycle; otherwise it is 1.
  - After node_num accepted words, step_cnt increments.
  - Then go to READ if step_cnt < num_steps, else to OUT.
- OUT:
  - EN_update_addr_X_n and _Wout_n are driven 0 for node_num cycles.
  - pe_rd_mode=1.
  - Then go to ODRAIN.
- pe_rd_valid and pe_rd_last are RD_LAT-deep shift-register copies of "read enable active" and "final enable cycle of sweep".
- Invariant: enables for X_B and W/Win/Winb/Wout are never low at the same time as EN_X_inSRAM_n.
- Counters saturate never. step_cnt wraps modulo 2^STEP_W, but num_steps bounds it.

Decomposition:
- Shared package esn_pkg:
  - state enum.
  - SRAM_State codes (ST_IDLE=00, ST_LOAD=01, ST_RUN=10).
  - block select codes SEL_X..SEL_WOUT, SEL_NONE=7.
- One natural sub-module, esn_rd_valid_pipe: the RD_LAT-deep valid/last shift register.

Test Plan:
- Reset check: assert nrst=0 mid-LOAD -> every output equals its reset value within the reset cycle; state returns to IDLE.
- Load with gaps (node_num=4): start_load, 20 beats with load_valid toggling 1,0,1 -> exactly 20 writes with SEL 0,0,0,0,1,...,4 and addr 0..3 repeating. Every gap cycle shows SEL=7. Then return to IDLE.
- Run num_steps=2 (node_num=4, RD_LAT=3):
  - Read enables are low 4 cycles.
  - pe_rd_valid is high 4 cycles starting 3 cycles later, with pe_rd_last on the 4th.
  - WB accepts 4 words; step_cnt goes 1 then 2.
  - Then an OUT sweep with pe_rd_mode=1; done pulses once; busy falls.
- WB backpressure: pe_wb_valid pattern 1,0,0,1,1,0,1 -> EN_X_inSRAM_n low exactly on the cycle after each 1. Transition to READ only after the 4th accept.
- num_steps=0 -> READ/WB are skipped; only the OUT sweep runs, then done.
- start_load and start_run together in IDLE -> LOAD is entered; start_run during LOAD is ignored.
